sr_imem_loader: RTL and testbench

SR_IMEM_LOADER -- requirements
Module: sr_imem_loader

---
 rtl/sr_imem_loader.sv | 161 ++++++++++++++++
 tb/tb_sr_imem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_imem_loader.sv
// Byte-stream boot loader: parses framed instruction words, writes them into
// instruction memory and releases the CPU reset once a frame checks out.
module sr_imem_loader #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           word_buf_q, word_buf_d;
    logic [7:0]            csum_q, csum_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;

    logic        accept;
    logic [15:0] n_words;

    assign in_ready  = (state_q != S_ERR);
    assign accept    = in_valid & in_ready;
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign n_words   = {in_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_buf_d  = word_buf_q;
        csum_d      = csum_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        // Registered off the current state, so release/assert lags DONE by a cycle.
        cpu_rst_n_d = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && in_data == HEADER) begin
                    state_d    = S_LEN0;
                    len_d      = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    csum_d  = csum_q + in_data;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d  = n_words;
                    csum_d = csum_q + in_data;
                    if (n_words == 16'd0)
                        state_d = S_CSUM;
                    else if ({1'b0, n_words} > MAX_WORDS)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_buf_d[7:0]   = in_data;
                        2'd1: word_buf_d[15:8]  = in_data;
                        2'd2: word_buf_d[23:16] = in_data;
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = word_cnt_q[ADDR_WIDTH-1:0];
                            wr_data_d = {in_data, word_buf_q};
                            if (word_cnt_q == len_q - 16'd1)
                                state_d = S_CSUM;
                            else
                                word_cnt_d = word_cnt_q + 16'd1;
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            S_ERR: begin
                if (clr) begin
                    state_d    = S_IDLE;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            word_buf_q  <= '0;
            csum_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_buf_q  <= word_buf_d;
            csum_q      <= csum_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

endmodule

// File: tb/tb_sr_imem_loader.sv
// Directed plus randomized frames for sr_imem_loader, checked against
// expected write lists and checksums built from the frame format.
module tb_sr_imem_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_rst_n;
    logic          done;
    logic          err;

    sr_imem_loader #(.ADDR_WIDTH(AW), .HEADER(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] ew[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(32'(wr_addr));
            wd.push_back(wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called right after a negedge; byte is offered across exactly one posedge.
    task automatic send(input logic [7:0] b, input int unsigned maxgap);
        int unsigned gap;
        gap = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, wa.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wa.size(); i++) begin
            chk({tag, "_addr"}, wa[i], 32'(i));
            chk({tag, "_data"}, wd[i], ew[i]);
        end
    endtask

    // Sends header, length, words from ew, then checksum (optionally corrupted).
    task automatic run_frame(input string tag, input bit bad, input int unsigned maxgap);
        logic [7:0]  sum;
        logic [15:0] n;
        logic [31:0] w;
        n   = 16'(ew.size());
        sum = n[7:0] + n[15:8];
        clear_writes();
        send(8'hA5, maxgap);
        send(n[7:0], maxgap);
        send(n[15:8], maxgap);
        foreach (ew[i]) begin
            w = ew[i];
            for (int k = 0; k < 4; k++) begin
                sum = sum + w[8*k +: 8];
                send(w[8*k +: 8], maxgap);
            end
        end
        send(bad ? ~sum : sum, maxgap);
        chk({tag, "_done"}, 32'(done), bad ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(err), bad ? 32'd1 : 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), bad ? 32'd0 : 32'd1);
        chk({tag, "_cpu0"}, 32'(cpu_rst_n), 32'd0);
        @(negedge clk);
        chk({tag, "_cpu1"}, 32'(cpu_rst_n), bad ? 32'd0 : 32'd1);
        chk_writes(tag);
    endtask

    task automatic pulse_clr(input string tag);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk({tag, "_clr_err"}, 32'(err), 32'd0);
        chk({tag, "_clr_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int unsigned n;
        bit          bad;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 32'(in_ready), 32'd1);

        // Two-word frame with correct checksum
        ew = '{32'h00100013, 32'h00500093};
        run_frame("good2", 1'b0, 0);

        // clr outside ERR has no effect
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_in_done", 32'(done), 32'd1);

        // Same frame, corrupted checksum: writes kept, CPU held in reset
        run_frame("bad2", 1'b1, 0);
        send(8'hA5, 0);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_cpu", 32'(cpu_rst_n), 32'd0);
        pulse_clr("bad2");

        // Length one beyond memory depth
        clear_writes();
        send(8'hA5, 0); send(8'h41, 0); send(8'h00, 0);
        chk("ovf_err", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        chk("ovf_nwr", wa.size(), 32'd0);
        pulse_clr("ovf");

        // Junk before header, then empty frame
        clear_writes();
        send(8'h00, 0); send(8'hFF, 0);
        chk("junk_idle", 32'(done | err), 32'd0);
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        chk("empty_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("empty_nwr", wa.size(), 32'd0);

        // Header in DONE restarts and re-asserts CPU reset
        send(8'hA5, 0);
        chk("hdr_done_exit", 32'(done), 32'd0);
        @(negedge clk);
        chk("hdr_cpu_fall", 32'(cpu_rst_n), 32'd0);

        // Reset mid-word, then a clean frame
        send(8'h02, 0); send(8'h00, 0); send(8'h13, 0); send(8'h00, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_wr_data", wr_data, 32'd0);
        chk("mid_cpu", 32'(cpu_rst_n), 32'd0);
        chk("mid_flags", 32'({done, err, wr_en}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rdy", 32'(in_ready), 32'd1);
        ew = '{32'h00100013, 32'h00500093};
        run_frame("after_rst", 1'b0, 0);

        // Same frame with random idle gaps
        run_frame("gaps", 1'b0, 4);

        // Full-depth frame
        ew.delete();
        for (int unsigned i = 0; i < (1 << AW); i++) ew.push_back($urandom);
        run_frame("full", 1'b0, 0);

        // Randomized frames
        for (int unsigned t = 0; t < 8; t++) begin
            n   = $urandom_range(1, 6);
            bad = ($urandom_range(0, 3) == 0);
            ew.delete();
            for (int unsigned i = 0; i < n; i++) ew.push_back($urandom);
            run_frame("rnd", bad, 3);
            if (bad) pulse_clr("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
